// File: rtl/fb_clear.sv
// Frame-buffer clear sequencer: while the st controller sits in RST, write CLEAR_VAL
// to every frame-buffer word through a valid/ready port, then hold rst_ok until st leaves RST.
`ifndef RST
`define RST 3'd1
`endif

module fb_clear #(
   parameter int                ADDR_W    = 12,
   parameter int                DATA_W    = 12,
   parameter int                DEPTH     = 4096,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        state,
   input  logic              wr_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic              rst_ok
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   // Last address compared explicitly so DEPTH == 2**ADDR_W never depends on wrap.
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   fsm_t              fsm_q;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;
   logic              in_rst;
   logic              accept;

   assign in_rst = (state == `RST);
   assign accept = (fsm_q == CLEAR) && wr_ready;
   assign addr_d = addr_q + ADDR_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q  <= IDLE;
         addr_q <= '0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (in_rst) begin
                  fsm_q  <= CLEAR;
                  addr_q <= '0;
               end
            end
            CLEAR: begin
               // Leaving RST mid-sweep abandons the sweep even if this cycle's write lands.
               if (!in_rst) begin
                  fsm_q  <= IDLE;
                  addr_q <= '0;
               end else if (accept) begin
                  if (addr_q == LAST_ADDR) begin
                     fsm_q  <= DONE;
                     addr_q <= '0;
                  end else begin
                     addr_q <= addr_d;
                  end
               end
            end
            DONE: begin
               if (!in_rst) begin
                  fsm_q  <= IDLE;
                  addr_q <= '0;
               end
            end
            default: begin
               fsm_q  <= IDLE;
               addr_q <= '0;
            end
         endcase
      end
   end

   assign wr_en   = (fsm_q == CLEAR);
   assign busy    = (fsm_q == CLEAR);
   assign rst_ok  = (fsm_q == DONE);
   assign wr_addr = (fsm_q == CLEAR) ? addr_q : '0;
   assign wr_data = CLEAR_VAL;

endmodule

// File: tb/tb_fb_clear.sv
// Scoreboard bench for fb_clear (DEPTH=16): expected writes are queued by the stimulus
// and popped by a monitor on every accepted write; control outputs are checked directly.
`ifndef RST
`define RST 3'd1
`endif
`ifndef SLEEP
`define SLEEP 3'd2
`endif
`ifndef STOP
`define STOP 3'd3
`endif

module tb_fb_clear;

   localparam int          AW  = 4;
   localparam int          DW  = 12;
   localparam int          DEP = 16;
   localparam logic [DW-1:0] CV = 12'h000;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    state;
   logic          wr_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          rst_ok;

   int vectors    = 0;
   int miscompares = 0;
   int accepts    = 0;
   logic [DW+AW-1:0] exp_q[$];

   fb_clear #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .CLEAR_VAL(CV)) dut (
      .clk(clk), .rst(rst), .state(state), .wr_ready(wr_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .rst_ok(rst_ok)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push_sweep(input int n);
      for (int a = 0; a < n; a++) exp_q.push_back({CV, AW'(a)});
   endtask

   // Monitor: a write is accepted at the next posedge when wr_en && wr_ready hold at negedge.
   always @(negedge clk) begin
      logic [DW+AW-1:0] e;
      if (!rst && wr_en && wr_ready) begin
         accepts++;
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: got addr %0h expected no write at %0t", wr_addr, $time);
         end else begin
            e = exp_q.pop_front();
            chk("sb_wr_addr", 32'(wr_addr), 32'(e[AW-1:0]));
            chk("sb_wr_data", 32'(wr_data), 32'(e[DW+AW-1:AW]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0;
      int st;
      rst = 1'b1; state = `SLEEP; wr_ready = 1'b0;
      // 1: asynchronous reset state before any clock edge
      #1;
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rst_ok", 32'(rst_ok), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 32'(CV));
      tick();
      rst = 1'b0;
      tick();

      // 2: full sweep with wr_ready high
      state = `RST; wr_ready = 1'b1;
      push_sweep(DEP);
      chk("t2_pre_wr_en", 32'(wr_en), 0);
      tick();
      for (int i = 0; i < DEP; i++) begin
         chk("t2_wr_en", 32'(wr_en), 1);
         chk("t2_wr_addr", 32'(wr_addr), 32'(i));
         chk("t2_rst_ok_low", 32'(rst_ok), 0);
         tick();
      end
      chk("t2_rst_ok", 32'(rst_ok), 1);
      chk("t2_done_wr_en", 32'(wr_en), 0);
      chk("t2_done_busy", 32'(busy), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t2_rst_ok_level", 32'(rst_ok), 1);
         chk("t2_no_retrigger", 32'(wr_en), 0);
      end
      state = `SLEEP;
      tick();
      chk("t2_rst_ok_drop", 32'(rst_ok), 0);
      chk("t2_idle_wr_en", 32'(wr_en), 0);
      tick();

      // 3: stall at address 7
      a0 = accepts;
      state = `RST; wr_ready = 1'b1;
      push_sweep(DEP);
      tick();
      for (int i = 0; i < 7; i++) tick();
      chk("t3_at7", 32'(wr_addr), 7);
      wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_stall_addr", 32'(wr_addr), 7);
         chk("t3_stall_wr_en", 32'(wr_en), 1);
      end
      wr_ready = 1'b1;
      for (int i = 7; i < DEP; i++) begin
         chk("t3_rst_ok_low", 32'(rst_ok), 0);
         tick();
      end
      chk("t3_rst_ok", 32'(rst_ok), 1);
      chk("t3_accepts", 32'(accepts - a0), 32'(DEP));
      state = `SLEEP;
      tick();
      chk("t3_rst_ok_drop", 32'(rst_ok), 0);

      // 4: abort at address 5; the write at 5 still lands
      state = `RST;
      push_sweep(6);
      tick();
      for (int i = 0; i < 5; i++) tick();
      chk("t4_at5", 32'(wr_addr), 5);
      state = `STOP;
      tick();
      chk("t4_abort_wr_en", 32'(wr_en), 0);
      chk("t4_abort_rst_ok", 32'(rst_ok), 0);
      chk("t4_abort_addr", 32'(wr_addr), 0);
      tick();
      chk("t4_abort_rst_ok2", 32'(rst_ok), 0);
      state = `RST;
      push_sweep(DEP);
      tick();
      chk("t4_restart_addr", 32'(wr_addr), 0);
      chk("t4_restart_wr_en", 32'(wr_en), 1);
      for (int i = 0; i < DEP; i++) tick();
      chk("t4_rst_ok", 32'(rst_ok), 1);
      state = `SLEEP;
      tick();

      // 5: asynchronous reset mid-sweep at address 9
      state = `RST;
      push_sweep(9);
      tick();
      for (int i = 0; i < 9; i++) tick();
      chk("t5_at9", 32'(wr_addr), 9);
      rst = 1'b1;
      #1;
      chk("t5_rst_wr_en", 32'(wr_en), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_addr", 32'(wr_addr), 0);
      chk("t5_rst_rst_ok", 32'(rst_ok), 0);
      tick();
      push_sweep(DEP);
      rst = 1'b0;
      chk("t5_release_wr_en", 32'(wr_en), 0);
      tick();
      chk("t5_restart_addr", 32'(wr_addr), 0);
      chk("t5_restart_wr_en", 32'(wr_en), 1);
      for (int i = 0; i < DEP; i++) tick();
      chk("t5_rst_ok", 32'(rst_ok), 1);
      state = `SLEEP;
      tick();

      // 6: no trigger from any non-RST encoding
      for (int i = 0; i < 100; i++) begin
         st = i % 7;
         if (st >= 1) st = st + 1;
         state = 3'(st);
         wr_ready = 1'(i % 2);
         tick();
         chk("t6_wr_en", 32'(wr_en), 0);
         chk("t6_rst_ok", 32'(rst_ok), 0);
      end

      chk("sb_drained", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
